// File: rtl/video_pkg.sv
// Shared types for the video processor instruction path: opcodes, field widths,
// dataA layout and the dispatcher FSM encoding.
package video_pkg;

  localparam int OPCODE_W = 4;
  localparam int TARGET_W = 14;
  localparam int DATA_W   = 32;
  localparam int CMD_W    = OPCODE_W + TARGET_W + DATA_W;

  localparam logic [OPCODE_W-1:0] OP_WR_REG = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_WR_MEM = 4'h1;

  // dataA = {14'b0, target, opcode}
  localparam int DA_OP_LSB  = 0;
  localparam int DA_TGT_LSB = DA_OP_LSB + OPCODE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [TARGET_W-1:0] target;
    logic [DATA_W-1:0]   data;
  } cmd_t;

  function automatic logic [31:0] pack_data_a(input logic [OPCODE_W-1:0] op,
                                              input logic [TARGET_W-1:0] tgt);
    logic [31:0] w;
    w = '0;
    w[DA_OP_LSB +: OPCODE_W]  = op;
    w[DA_TGT_LSB +: TARGET_W] = tgt;
    return w;
  endfunction

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_WR_REG) || (op == OP_WR_MEM);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head; 0-cycle read latency.
// Push is ignored when full and pop when empty; simultaneous push and pop are allowed.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// Buffers host commands and issues them as dataA/dataB + one-cycle wr_en, 3 cycles after a push into an
// empty FIFO; holds while printing_screen is set; cmd_ready = !full. DISPATCH_STATS_EN adds stat counters.
module instruction_dispatcher
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [13:0] cmd_target,
  input  logic [31:0] cmd_data,
  input  logic        printing_screen,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic        wr_en,
  output logic        busy,
`ifdef DISPATCH_STATS_EN
  output logic [15:0] stat_issued,
  output logic [15:0] stat_stall,
`endif
  output logic        err_illegal
);

  localparam logic [7:0] GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic   scr_meta;
  logic   scr_s;
  cmd_t   wr_cmd;
  cmd_t   head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   head_legal;
  state_t state;
  state_t state_nxt;
  logic [7:0] gap_cnt;

  // Reset to 1 so nothing issues until the synchronizer has sampled the real flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scr_meta <= 1'b1;
      scr_s    <= 1'b1;
    end else begin
      scr_meta <= printing_screen;
      scr_s    <= scr_meta;
    end
  end

  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign wr_cmd     = {cmd_opcode, cmd_target, cmd_data};
  assign head_legal = is_legal(head.opcode);
  assign busy       = (state != ST_IDLE) || !empty;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_cmd_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wr_dat (wr_cmd),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!head_legal) begin
          pop       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!scr_s) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        pop       = 1'b1;
        state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= 8'd0;
    end else if (state == ST_ISSUE) begin
      gap_cnt <= GAP_INIT;
    end else if ((state == ST_GAP) && (gap_cnt != 8'd0)) begin
      gap_cnt <= gap_cnt - 8'd1;
    end
  end

  // The strobe and its data words leave ISSUE together on the same edge as the pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataA       <= 32'd0;
      dataB       <= 32'd0;
      wr_en       <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      wr_en       <= (state == ST_ISSUE);
      err_illegal <= (state == ST_CHECK) && !head_legal;
      if (state == ST_ISSUE) begin
        dataA <= pack_data_a(head.opcode, head.target);
        dataB <= head.data;
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued <= 16'd0;
      stat_stall  <= 16'd0;
    end else begin
      if ((state == ST_ISSUE) && (stat_issued != 16'hffff))
        stat_issued <= stat_issued + 16'd1;
      if ((state == ST_CHECK) && scr_s && (stat_stall != 16'hffff))
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule
